// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer in front of data_mem: splits any-alignment accesses into
// one or two doubleword cycles, merging stores by read-modify-write.
module lsu_mem_ctrl #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [63:0]           req_wdata,
    output logic                  resp_valid,
    output logic [63:0]           resp_rdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [63:0]           mem_wdata,
    input  logic [63:0]           mem_rdata
);

    // state  | meaning
    // IDLE   | ready for a request, memory idle
    // LO     | access dword holding the first byte
    // HI     | access the following dword (spanning requests only)
    // RESP   | one-cycle completion pulse
    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_RESP} state_t;

    state_t                r_state;
    logic                  r_we;
    logic [1:0]            r_size;
    logic                  r_signed;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [63:0]           r_wdata;
    logic [63:0]           r_lo_buf;
    logic [63:0]           r_hi_buf;

    logic [2:0]            w_off;
    logic [3:0]            w_nbytes;
    logic                  w_span;
    logic [7:0]            w_size_mask;
    logic [15:0]           w_bmask;
    logic [127:0]          w_wdata_sh;
    logic [ADDR_WIDTH-1:0] w_lo_addr;
    logic [ADDR_WIDTH-1:0] w_hi_addr;
    logic [7:0]            w_mask_cur;
    logic [63:0]           w_data_cur;
    logic [63:0]           w_merged;
    logic [63:0]           w_shifted;
    logic [63:0]           w_load;
    logic                  w_we_raw;

    assign w_off    = r_addr[2:0];
    assign w_nbytes = 4'd1 << r_size;
    assign w_span   = ({1'b0, w_off} + w_nbytes) > 4'd8;

    always_comb begin
        case (r_size)
            2'd0:    w_size_mask = 8'h01;
            2'd1:    w_size_mask = 8'h03;
            2'd2:    w_size_mask = 8'h0F;
            default: w_size_mask = 8'hFF;
        endcase
    end

    // Byte mask and data laid out across the 16-byte LO/HI window.
    assign w_bmask    = {8'h00, w_size_mask} << w_off;
    assign w_wdata_sh = {64'h0, r_wdata} << {w_off, 3'b000};

    assign w_lo_addr  = {r_addr[ADDR_WIDTH-1:3], 3'b000};
    assign w_hi_addr  = w_lo_addr + ADDR_WIDTH'(8);

    assign w_mask_cur = (r_state == S_HI) ? w_bmask[15:8] : w_bmask[7:0];
    assign w_data_cur = (r_state == S_HI) ? w_wdata_sh[127:64] : w_wdata_sh[63:0];

    always_comb begin
        w_merged = mem_rdata;
        for (int b = 0; b < 8; b++) begin
            if (w_mask_cur[b]) w_merged[b*8 +: 8] = w_data_cur[b*8 +: 8];
        end
    end

    always_comb begin
        w_shifted = 64'({r_hi_buf, r_lo_buf} >> {w_off, 3'b000});
        case (r_size)
            2'd0:    w_load = {{56{r_signed & w_shifted[7]}},  w_shifted[7:0]};
            2'd1:    w_load = {{48{r_signed & w_shifted[15]}}, w_shifted[15:0]};
            2'd2:    w_load = {{32{r_signed & w_shifted[31]}}, w_shifted[31:0]};
            default: w_load = w_shifted;
        endcase
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = (resp_valid && !r_we) ? w_load : 64'h0;

    // Reset gates the write strobe directly so an abort never corrupts memory.
    assign w_we_raw  = r_we && ((r_state == S_LO) || (r_state == S_HI));
    assign mem_we    = w_we_raw && rst_n;
    assign mem_wdata = w_we_raw ? w_merged : 64'h0;

    always_comb begin
        case (r_state)
            S_LO:    mem_addr = w_lo_addr;
            S_HI:    mem_addr = w_hi_addr;
            default: mem_addr = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_we     <= 1'b0;
            r_size   <= 2'd0;
            r_signed <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= 64'h0;
            r_lo_buf <= 64'h0;
            r_hi_buf <= 64'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_size   <= req_size;
                        r_signed <= req_signed;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_lo_buf <= 64'h0;
                        r_hi_buf <= 64'h0;
                        r_state  <= S_LO;
                    end
                end
                S_LO: begin
                    if (!r_we) r_lo_buf <= mem_rdata;
                    r_state <= w_span ? S_HI : S_RESP;
                end
                S_HI: begin
                    if (!r_we) r_hi_buf <= mem_rdata;
                    r_state <= S_RESP;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a behavioural data_mem (async read,
// sync write) and hand-computed expected values.
module tb_lsu_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [11:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    logic [63:0] mem [0:511];
    logic        pre_en;
    logic [8:0]  pre_idx;
    logic [63:0] pre_data;

    logic [11:0] addr_log [$];
    int          resp_cnt;
    int          n_checks;
    int          n_fail;

    lsu_mem_ctrl #(.ADDR_WIDTH(12)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[11:3]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[11:3]] <= mem_wdata;
        else if (pre_en) mem[pre_idx] <= pre_data;
    end

    // Record the address of every LO/HI memory cycle and count response pulses.
    always @(negedge clk) begin
        if (rst_n && !req_ready && !resp_valid) addr_log.push_back(mem_addr);
        if (resp_valid) resp_cnt = resp_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    task automatic preload(input logic [8:0] idx, input logic [63:0] data);
        @(negedge clk);
        pre_en = 1'b1; pre_idx = idx; pre_data = data;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    // Issues one request; lat = edges after the accept edge until resp_valid, -1 on timeout.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [11:0] addr, input logic [63:0] wd,
                          output int lat, output logic [63:0] rd);
        @(negedge clk);
        addr_log.delete();
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = -1;
        rd  = 64'hx;
        for (int k = 1; k <= 8 && lat < 0; k++) begin
            @(posedge clk);
            #1;
            if (resp_valid) begin
                lat = k;
                rd  = resp_rdata;
            end
        end
        @(posedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        n_checks++; if (resp_rdata !== 64'h0) begin n_fail++; $display("FAIL reset_resp_rdata: got %h expected 0", resp_rdata); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        n_checks++; if (mem_addr !== 12'h000) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 000", mem_addr); end
    endtask

    task automatic test_load_extract;
        int lat;
        logic [63:0] rd;
        preload(9'd3, 64'h0123_4567_89AB_CDEF);
        do_req(1'b0, 2'd0, 1'b0, 12'h018, 64'h0, lat, rd);
        n_checks++; if (rd !== 64'h0000_0000_0000_00EF) begin n_fail++; $display("FAIL lb_unsigned: got %h expected 00000000000000ef", rd); end
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL lb_latency: got %0d expected 1", lat); end
        n_checks++; if (addr_log.size() !== 1 || addr_log[0] !== 12'h018) begin n_fail++; $display("FAIL lb_access: got %0d accesses expected 1 at 018", addr_log.size()); end
        do_req(1'b0, 2'd0, 1'b1, 12'h018, 64'h0, lat, rd);
        n_checks++; if (rd !== 64'hFFFF_FFFF_FFFF_FFEF) begin n_fail++; $display("FAIL lb_signed: got %h expected ffffffffffffffef", rd); end
        do_req(1'b0, 2'd1, 1'b0, 12'h01A, 64'h0, lat, rd);
        n_checks++; if (rd !== 64'h0000_0000_0000_89AB) begin n_fail++; $display("FAIL lh_unsigned: got %h expected 00000000000089ab", rd); end
        do_req(1'b0, 2'd2, 1'b1, 12'h01C, 64'h0, lat, rd);
        n_checks++; if (rd !== 64'h0000_0000_0123_4567) begin n_fail++; $display("FAIL lw_signed_pos: got %h expected 0000000001234567", rd); end
    endtask

    task automatic test_span_load;
        int lat;
        logic [63:0] rd;
        preload(9'd4, 64'hDEAD_BEEF_CAFE_F00D);
        preload(9'd5, 64'h0000_0000_0000_0080);
        do_req(1'b0, 2'd3, 1'b0, 12'h01C, 64'h0, lat, rd);
        n_checks++; if (rd !== 64'hCAFE_F00D_0123_4567) begin n_fail++; $display("FAIL ld_span: got %h expected cafef00d01234567", rd); end
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL ld_span_latency: got %0d expected 2", lat); end
        n_checks++; if (addr_log.size() !== 2 || addr_log[0] !== 12'h018 || addr_log[1] !== 12'h020) begin n_fail++; $display("FAIL ld_span_addrs: got %0d accesses expected 018,020", addr_log.size()); end
        do_req(1'b0, 2'd1, 1'b1, 12'h027, 64'h0, lat, rd);
        n_checks++; if (rd !== 64'hFFFF_FFFF_FFFF_80DE) begin n_fail++; $display("FAIL lh_span_signed: got %h expected ffffffffffff80de", rd); end
    endtask

    task automatic test_store_merge;
        int lat;
        logic [63:0] rd;
        preload(9'd1, 64'h0000_0000_0000_0002);
        preload(9'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        do_req(1'b1, 2'd0, 1'b0, 12'h009, 64'hFFFF_FFFF_FFFF_FFAA, lat, rd);
        n_checks++; if (mem[1] !== 64'h0000_0000_0000_AA02) begin n_fail++; $display("FAIL sb_merge: got %h expected 000000000000aa02", mem[1]); end
        n_checks++; if (rd !== 64'h0) begin n_fail++; $display("FAIL sb_rdata: got %h expected 0", rd); end
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL sb_latency: got %0d expected 1", lat); end
        do_req(1'b1, 2'd2, 1'b0, 12'h00E, 64'h0000_0000_1122_3344, lat, rd);
        n_checks++; if (mem[1] !== 64'h3344_0000_0000_AA02) begin n_fail++; $display("FAIL sw_span_lo: got %h expected 334400000000aa02", mem[1]); end
        n_checks++; if (mem[2] !== 64'hFFFF_FFFF_FFFF_1122) begin n_fail++; $display("FAIL sw_span_hi: got %h expected ffffffffffff1122", mem[2]); end
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL sw_span_latency: got %0d expected 2", lat); end
    endtask

    task automatic test_wrap;
        int lat;
        logic [63:0] rd;
        preload(9'd511, 64'h8877_6655_4433_2211);
        preload(9'd0, 64'h0000_0000_0000_0001);
        do_req(1'b0, 2'd3, 1'b0, 12'hFFC, 64'h0, lat, rd);
        n_checks++; if (rd !== 64'h0000_0001_8877_6655) begin n_fail++; $display("FAIL ld_wrap: got %h expected 0000000188776655", rd); end
        n_checks++; if (addr_log.size() !== 2 || addr_log[0] !== 12'hFF8 || addr_log[1] !== 12'h000) begin n_fail++; $display("FAIL ld_wrap_addrs: got %0d accesses expected ff8,000", addr_log.size()); end
    endtask

    task automatic test_back_to_back;
        int c0;
        c0 = resp_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 12'h01F; req_wdata = 64'h0;
        @(posedge clk);
        #1;
        req_addr = 12'h018; req_size = 2'd3; req_signed = 1'b1;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_ready: got %b expected 0", req_ready); end
        @(posedge clk);
        #1;
        n_checks++; if (resp_valid !== 1'b1 || resp_rdata !== 64'h0000_0000_0000_0001) begin n_fail++; $display("FAIL b2b_held_fields: got valid %b data %h expected 1 0000000000000001", resp_valid, resp_rdata); end
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_resp_ready: got %b expected 0", req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_return_idle: got ready %b valid %b expected 1 0", req_ready, resp_valid); end
        n_checks++; if (resp_cnt - c0 !== 1) begin n_fail++; $display("FAIL b2b_resp_count: got %0d expected 1", resp_cnt - c0); end
    endtask

    task automatic test_reset_mid_store;
        int c0;
        int lat;
        logic [63:0] rd;
        preload(9'd1, 64'h1111_2222_3333_4444);
        preload(9'd2, 64'h5555_6666_7777_8888);
        c0 = resp_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 12'h00E; req_wdata = 64'h0000_0000_1122_3344;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n_checks++; if (mem_we !== 1'b1 || mem_addr !== 12'h008) begin n_fail++; $display("FAIL rst_lo_write: got we %b addr %h expected 1 008", mem_we, mem_addr); end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_hi_we_gated: got %b expected 0", mem_we); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b expected 1", req_ready); end
        n_checks++; if (mem[2] !== 64'h5555_6666_7777_8888) begin n_fail++; $display("FAIL rst_hi_unchanged: got %h expected 5555666677778888", mem[2]); end
        n_checks++; if (mem[1] !== 64'h3344_2222_3333_4444) begin n_fail++; $display("FAIL rst_lo_committed: got %h expected 3344222233334444", mem[1]); end
        n_checks++; if (resp_cnt !== c0) begin n_fail++; $display("FAIL rst_no_resp: got %0d pulses expected 0", resp_cnt - c0); end
        do_req(1'b0, 2'd3, 1'b0, 12'h010, 64'h0, lat, rd);
        n_checks++; if (rd !== 64'h5555_6666_7777_8888 || lat !== 1) begin n_fail++; $display("FAIL rst_followup_load: got %h lat %0d expected 5555666677778888 lat 1", rd, lat); end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        resp_cnt   = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 12'h000;
        req_wdata  = 64'h0;
        pre_en     = 1'b0;
        pre_idx    = 9'd0;
        pre_data   = 64'h0;

        test_reset;
        test_load_extract;
        test_span_load;
        test_store_merge;
        test_wrap;
        test_back_to_back;
        test_reset_mid_store;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store sequencer between the execute stage and `data_mem`. It is the direct upstream feeder of `data_mem`'s `addr`/`we`/`wdata` ports and the consumer of its `rdata`.
- Converts byte/half/word/doubleword requests, aligned or misaligned, into one or two 64-bit doubleword accesses.
- Stores use read-merge-write, relying on `data_mem`'s asynchronous read and synchronous write. Loads are extracted and sign/zero-extended.
- Simple valid/ready request handshake and a one-cycle response pulse.

Parameters:
- ADDR_WIDTH, 12, byte-address width; must match `data_mem` ADDR_WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = doubleword.
- req_signed  in  1  sign-extend load result; ignored for stores and for size 3.
- req_addr  in  ADDR_WIDTH  byte address; any alignment allowed.
- req_wdata  in  64  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse for loads and stores.
- resp_rdata  out  64  load result; 0 for stores.
- mem_we  out  1  to `data_mem` we.
- mem_addr  out  ADDR_WIDTH  to `data_mem` addr; low 3 bits always 0.
- mem_wdata  out  64  to `data_mem` wdata.
- mem_rdata  in  64  from `data_mem` rdata (combinational).

Behaviour:
- Reset: rst_n is sampled low at a rising edge.
  - state goes to IDLE.
  - resp_valid = 0, resp_rdata = 0, all internal latches cleared.
  - req_ready = 1 from the next cycle.
- mem_we is gated by rst_n combinationally. No memory write occurs in any cycle where rst_n is low, including reset asserted mid-operation.
- States:
  - IDLE: req_ready = 1, mem_we = 0, mem_addr = 0. If req_valid, latch we/size/signed/addr/wdata and go to LO.
  - LO: mem_addr = {addr[AW-1:3], 000}. Loads capture mem_rdata into lo_buf. Stores drive mem_we = 1 with mem_wdata = mem_rdata, with the affected bytes replaced. Go to HI if off + nbytes > 8, else RESP.
  - HI: mem_addr = LO address + 8, modulo 2^ADDR_WIDTH (wraps to 0). Loads capture into hi_buf; stores merge the remaining upper bytes. Go to RESP.
  - RESP: resp_valid = 1 and resp_rdata valid for exactly this cycle. req_ready = 0. Go to IDLE.
- Definitions: off = addr[2:0]; nbytes = 1 << size.
- req_ready is high only in IDLE. There is no back-to-back acceptance; throughput is one request per 3 cycles aligned, 4 cycles split.
- Latency, with the accept edge as edge 0:
  - Non-spanning: resp_valid is high in the cycle after edge 1.
  - Spanning: resp_valid is high in the cycle after edge 2.
- Byte order is little-endian.
  - Store byte k of req_wdata (k < nbytes) goes to byte address addr + k.
  - Load result = ({hi_buf, lo_buf} >> 8·off), truncated to nbytes.
  - If req_signed and size < 3, sign-extend from the top byte; otherwise zero-extend.
- Unaffected bytes of a merged dword are written back unchanged.
- Spanning store: the LO write commits at the LO edge. HI reads the already-updated memory and is independent of it.
- req_valid while not in IDLE is ignored, since req_ready = 0. Latched request fields do not change until RESP completes.

Test Plan:
- Preload dword 0x018 = 0x0123_4567_89AB_CDEF. Load byte at 0x018, unsigned → 0x0000_0000_0000_00EF; signed → 0xFFFF_FFFF_FFFF_FFEF. resp_valid is high 2 cycles after accept.
- Same preload. Load half at 0x01A, unsigned → 0x0000_0000_0000_89AB. Load word at 0x01C, signed → 0x0000_0000_0123_4567.
- Preload dword 0x020 = 0xDEAD_BEEF_CAFE_F00D. Misaligned dword load at 0x01C → 0xCAFE_F00D_0123_4567. Two mem accesses (0x018, then 0x020); resp_valid 3 cycles after accept.
- Dword 0x008 = 0x0000_0000_0000_0002 and dword 0x010 = all ones.
  - Store byte 0xAA at 0x009 → dword 0x008 = 0x0000_0000_0000_AA02.
  - Then store word 0x1122_3344 at 0x00E → dword 0x008 = 0x3344_0000_0000_AA02 and dword 0x010 = 0xFFFF_FFFF_FFFF_1122.
- Wrap-around: dword 0xFF8 = 0x8877_6655_4433_2211 and dword 0x000 = 0x0000_0000_0000_0001. Dword load at 0xFFC → 0x0000_0001_8877_6655. mem_addr sequence is 0xFF8, then 0x000.
- Reset mid-store:
  - Start a spanning store.
  - Drive rst_n low during the HI cycle: mem_we is 0 in that cycle, the HI dword is unchanged, and resp_valid never pulses.
  - req_ready = 1 after release.
  - A following aligned load completes normally.
